md_stall_ctrl: RTL and testbench

- Sequencing controller for the multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the Execute stage.
- Detects a mult/div instruction held in the DX latch and issues a one-cycle start pulse to the multdiv unit.
- Holds PC/FD/DX frozen and bubbles the XM latch until the result or a timeout arrives.
- Then presents one writeback (result to rd, or an exception code to r30) for substitution into the XM latch inputs.

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_cycle_counter.sv | 35 +++
 rtl/md_stall_ctrl.sv | 104 ++++++++++
 tb/tb_md_stall_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencing controller.
package md_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } md_state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

  localparam logic [31:0] EXC_MULT    = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;
  localparam logic [4:0]  RSTATUS_REG = 5'd30;

  function automatic logic [31:0] exc_code(input md_op_e op);
    return (op == OP_MULT) ? EXC_MULT : EXC_DIV;
  endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Saturating WAIT-cycle counter with synchronous clear/enable and terminal-count flag.
module md_cycle_counter #(
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/md_stall_ctrl.sv
// Execute-stage sequencer: starts the multdiv unit, stalls the front end, and
// presents a single writeback (result or exception code) when it completes.
module md_stall_ctrl #(
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_is_mult,
  input  logic        dx_is_div,
  input  logic [4:0]  dx_rd,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        timeout
);
  import md_pkg::*;

  md_state_e   state_q;
  md_op_e      op_q;
  logic [4:0]  rd_q;
  logic [31:0] res_q;
  logic        exc_q;
  logic        timeout_q;
  logic        go;
  logic        tc;

  assign go = dx_is_mult | dx_is_div;

  md_cycle_counter #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (state_q == S_START),
    .en_i  (state_q == S_WAIT),
    .tc_o  (tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULT;
      rd_q      <= '0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            op_q    <= dx_is_mult ? OP_MULT : OP_DIV;
            rd_q    <= dx_rd;
            state_q <= S_START;
          end
        end
        S_START: begin
          timeout_q <= 1'b0;
          exc_q     <= 1'b0;
          res_q     <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the limit cycle takes priority over the timeout.
          if (md_ready) begin
            res_q   <= md_result;
            exc_q   <= md_exception;
            state_q <= S_DONE;
          end else if (tc) begin
            exc_q     <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_mult = (state_q == S_START) && (op_q == OP_MULT);
    ctrl_div  = (state_q == S_START) && (op_q == OP_DIV);
    stall     = (state_q == S_IDLE) ? go : (state_q != S_DONE);
    busy      = (state_q != S_IDLE);
    timeout   = timeout_q;
    wb_valid  = (state_q == S_DONE);
    wb_rd     = '0;
    wb_data   = '0;
    if (state_q == S_DONE) begin
      wb_rd   = exc_q ? RSTATUS_REG : rd_q;
      wb_data = exc_q ? exc_code(op_q) : res_q;
    end
  end

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Bench for md_stall_ctrl: directed vector table, hand sequences and random ops
// checked against a per-operation timeline model.
module tb_md_stall_ctrl;

  localparam int unsigned MAX = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        dx_is_mult, dx_is_div;
  logic [4:0]  dx_rd;
  logic [31:0] md_result;
  logic        md_exception, md_ready;
  logic        ctrl_mult, ctrl_div, stall, wb_valid, busy, timeout;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  md_stall_ctrl #(.MAX_CYCLES(40), .CNT_W(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .dx_is_mult   (dx_is_mult),
    .dx_is_div    (dx_is_div),
    .dx_rd        (dx_rd),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: got time limit want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        m;
    logic        d;
    logic [4:0]  rd;
    int unsigned n;      // WAIT cycle in which md_ready arrives; > MAX means never
    logic [31:0] res;
    logic        exc;
    logic [4:0]  x_rd;
    logic [31:0] x_data;
    logic        x_to;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic noise_md();
    md_ready     = 1'($urandom_range(0, 1));
    md_result    = $urandom;
    md_exception = 1'($urandom_range(0, 1));
  endtask

  // Writeback expected from the architectural rule, independent of timing.
  function automatic void model(input logic m, input int unsigned n, input logic [4:0] rd,
                                input logic [31:0] res, input logic exc,
                                output logic [4:0] x_rd, output logic [31:0] x_data,
                                output logic x_to);
    x_to = (n > MAX);
    if (x_to || exc) begin
      x_rd   = 5'd30;
      x_data = m ? 32'd4 : 32'd5;
    end else begin
      x_rd   = rd;
      x_data = res;
    end
  endfunction

  task automatic run_idle(input int unsigned cycles, input logic x_to);
    for (int unsigned i = 0; i < cycles; i++) begin
      dx_is_mult = 1'b0;
      dx_is_div  = 1'b0;
      dx_rd      = 5'($urandom);
      noise_md();
      #4;
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ctrl", 32'({ctrl_mult, ctrl_div}), 32'd0);
      chk("idle_wbv", 32'(wb_valid), 32'd0);
      chk("idle_wbrd", 32'(wb_rd), 32'd0);
      chk("idle_wbdata", wb_data, 32'd0);
      chk("idle_timeout", 32'(timeout), 32'(x_to));
      next_cycle();
    end
  endtask

  // Cycle k=0 is detection, k=1 START, k=2..lat+1 WAIT, k=lat+2 DONE.
  task automatic run_op(input vec_t v);
    int unsigned lat;
    logic        timed;
    logic        in_wait;
    logic        wbv;
    timed = (v.n > MAX);
    lat   = timed ? MAX : v.n;
    for (int unsigned k = 0; k <= lat + 2; k++) begin
      dx_is_mult = v.m;
      dx_is_div  = v.d;
      dx_rd      = v.rd;
      in_wait    = (k >= 2) && (k <= lat + 1);
      if (in_wait) begin
        md_ready     = !timed && (k - 1 == v.n);
        md_result    = md_ready ? v.res : $urandom;
        md_exception = md_ready ? v.exc : 1'($urandom_range(0, 1));
      end else begin
        noise_md();
      end
      #4;
      wbv = (k == lat + 2);
      chk("stall", 32'(stall), 32'(k <= lat + 1));
      chk("busy", 32'(busy), 32'(k >= 1));
      chk("ctrl_mult", 32'(ctrl_mult), 32'(k == 1 && v.m));
      chk("ctrl_div", 32'(ctrl_div), 32'(k == 1 && !v.m && v.d));
      chk("wb_valid", 32'(wb_valid), 32'(wbv));
      chk("wb_rd", 32'(wb_rd), wbv ? 32'(v.x_rd) : 32'd0);
      chk("wb_data", wb_data, wbv ? v.x_data : 32'd0);
      if (k >= 2) chk("timeout", 32'(timeout), wbv ? 32'(v.x_to) : 32'd0);
      next_cycle();
    end
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{1'b1, 1'b0, 5'd5,  3,  32'h0000002A, 1'b0, 5'd5,  32'h0000002A, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 5'd7,  2,  32'h12345678, 1'b1, 5'd30, 32'd5,        1'b0};
    tbl[2] = '{1'b1, 1'b0, 5'd12, 41, 32'h0,        1'b0, 5'd30, 32'd4,        1'b1};
    tbl[3] = '{1'b1, 1'b0, 5'd9,  40, 32'hCAFEF00D, 1'b0, 5'd9,  32'hCAFEF00D, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 5'd0,  1,  32'hDEADBEEF, 1'b0, 5'd0,  32'hDEADBEEF, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 5'd17, 5,  32'h55AA55AA, 1'b1, 5'd30, 32'd4,        1'b0};
    tbl[6] = '{1'b0, 1'b1, 5'd21, 45, 32'h0,        1'b0, 5'd30, 32'd5,        1'b1};
    tbl[7] = '{1'b1, 1'b0, 5'd2,  40, 32'h11111111, 1'b1, 5'd30, 32'd4,        1'b0};

    reset = 1'b1;
    dx_is_mult = 1'b0; dx_is_div = 1'b0; dx_rd = '0;
    md_ready = 1'b0; md_result = '0; md_exception = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    run_idle(2, 1'b0);

    foreach (tbl[i]) begin
      run_op(tbl[i]);
      run_idle(1, tbl[i].x_to);
    end

    // Back-to-back mult then div, then no third start.
    v = '{1'b1, 1'b0, 5'd3, 4, 32'h00000333, 1'b0, 5'd3, 32'h00000333, 1'b0};
    run_op(v);
    v = '{1'b0, 1'b1, 5'd4, 2, 32'h00000444, 1'b0, 5'd4, 32'h00000444, 1'b0};
    run_op(v);
    run_idle(3, 1'b0);

    // Reset during the second WAIT cycle aborts with no writeback.
    for (int unsigned k = 0; k <= 3; k++) begin
      dx_is_mult = 1'b1; dx_is_div = 1'b0; dx_rd = 5'd9;
      md_ready = 1'b0;
      reset = (k == 3);
      #4;
      chk("rst_pre_stall", 32'(stall), 32'd1);
      next_cycle();
    end
    reset = 1'b0;
    dx_is_mult = 1'b0;
    #4;
    chk("rst_outs", 32'({ctrl_mult, ctrl_div, stall, wb_valid, busy, timeout}), 32'd0);
    chk("rst_wb", {27'd0, wb_rd} | wb_data, 32'd0);
    next_cycle();
    for (int unsigned k = 0; k < 3; k++) begin
      md_ready = 1'b1; md_result = 32'hBADC0DE0; md_exception = 1'b0;
      #4;
      chk("rst_after_wbv", 32'(wb_valid), 32'd0);
      chk("rst_after_busy", 32'(busy), 32'd0);
      next_cycle();
    end

    // Random operations with random idle gaps.
    for (int i = 0; i < 20; i++) begin
      v.m = 1'($urandom_range(0, 1));
      v.d = v.m ? 1'($urandom_range(0, 1)) : 1'b1;
      v.rd = 5'($urandom);
      v.n = $urandom_range(1, 42);
      v.res = $urandom;
      v.exc = ($urandom_range(0, 3) == 0);
      model(v.m, v.n, v.rd, v.res, v.exc, v.x_rd, v.x_data, v.x_to);
      run_op(v);
      run_idle($urandom_range(0, 2), v.x_to);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
